bin_window_vote: RTL and testbench



---
 rtl/bin_window_vote_pkg.sv | 20 ++
 rtl/bin_window_vote_if.sv | 24 ++
 rtl/bin_window_vote_popcount_k.sv | 19 +
 rtl/bin_window_vote.sv | 113 +++++++++++
 tb/tb_bin_window_vote.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bin_window_vote_pkg.sv
// Shared definitions for the binarised-pixel window filters.
package bin_window_vote_pkg;

  typedef enum logic [1:0] {
    MODE_THRESH = 2'd0,
    MODE_ERODE  = 2'd1,
    MODE_DILATE = 2'd2,
    MODE_MAJ    = 2'd3
  } mode_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_window_vote_if.sv
// Column stream in, filtered pixel stream out, plus per-line config.
interface bin_window_vote_if #(
  parameter int K    = 5,
  parameter int SUMW = $clog2(K*K+1)
);
  logic            in_valid;
  logic            in_sol;
  logic [K-1:0]    in_col;
  logic [1:0]      cfg_mode;
  logic [SUMW-1:0] cfg_thresh;
  logic            out_valid;
  logic            out_sol;
  logic            out_bit;

  modport master (
    output in_valid, in_sol, in_col, cfg_mode, cfg_thresh,
    input  out_valid, out_sol, out_bit
  );

  modport slave (
    input  in_valid, in_sol, in_col, cfg_mode, cfg_thresh,
    output out_valid, out_sol, out_bit
  );
endinterface

// File: rtl/bin_window_vote_popcount_k.sv
// Combinational population count of a K-bit vector.
module popcount_k
  import bin_window_vote_pkg::*;
#(
  parameter int K = 5,
  parameter int W = clog2(K+1)
) (
  input  logic [K-1:0] in_col,
  output logic [W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < K; i++) begin
      cnt = cnt + W'(in_col[i]);
    end
  end

endmodule

// File: rtl/bin_window_vote.sv
// KxK binary window filter: running column-count sum, per-line shadowed mode.
module bin_window_vote
  import bin_window_vote_pkg::*;
#(
  parameter int K        = 5,
  parameter int SUMW     = $clog2(K*K+1),
  parameter bit EDGE_VAL = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  bin_window_vote_if.slave bus
);

  localparam int PCW = clog2(K+1);
  localparam logic [SUMW-1:0] KK   = SUMW'(K*K);
  localparam logic [SUMW-1:0] HALF = SUMW'((K*K)/2);
  localparam logic [PCW-1:0]  KC   = PCW'(K);

  logic [PCW-1:0]  pc;
  logic [PCW-1:0]  hist [K];
  logic [SUMW-1:0] sum, sum_nx;
  logic [PCW-1:0]  col_cnt, col_cnt_nx;
  mode_e           shd_mode, shd_mode_nx;
  logic [SUMW-1:0] shd_thresh, shd_thresh_nx;

  logic            valid_r, sol_r, full_r;
  logic [SUMW-1:0] sum_r, thresh_r;
  mode_e           mode_r;
  logic            cmp;
  logic            out_valid_q, out_sol_q, out_bit_q;

  popcount_k #(.K(K), .W(PCW)) u_popcount (
    .in_col (bus.in_col),
    .cnt    (pc)
  );

  always_comb begin
    sum_nx        = sum + SUMW'(pc) - SUMW'(hist[K-1]);
    col_cnt_nx    = (col_cnt == KC) ? KC : col_cnt + PCW'(1);
    shd_mode_nx   = shd_mode;
    shd_thresh_nx = shd_thresh;
    if (bus.in_sol) begin
      sum_nx        = SUMW'(pc);
      col_cnt_nx    = PCW'(1);
      shd_mode_nx   = mode_e'(bus.cfg_mode);
      shd_thresh_nx = bus.cfg_thresh;
    end
  end

  // Stage 1 captures the next-state window so latency is two clocks;
  // the line's config travels with its data across the line boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < K; i++) hist[i] <= '0;
      sum        <= '0;
      col_cnt    <= '0;
      shd_mode   <= MODE_THRESH;
      shd_thresh <= KK - SUMW'(2);
      valid_r    <= 1'b0;
      sol_r      <= 1'b0;
      full_r     <= 1'b0;
      sum_r      <= '0;
      thresh_r   <= '0;
      mode_r     <= MODE_THRESH;
    end else begin
      valid_r <= bus.in_valid;
      sol_r   <= 1'b0;
      if (bus.in_valid) begin
        hist[0] <= pc;
        for (int unsigned i = 1; i < K; i++) begin
          hist[i] <= bus.in_sol ? '0 : hist[i-1];
        end
        sum        <= sum_nx;
        col_cnt    <= col_cnt_nx;
        shd_mode   <= shd_mode_nx;
        shd_thresh <= shd_thresh_nx;
        sum_r      <= sum_nx;
        full_r     <= (col_cnt_nx == KC);
        sol_r      <= bus.in_sol;
        mode_r     <= shd_mode_nx;
        thresh_r   <= shd_thresh_nx;
      end
    end
  end

  always_comb begin
    cmp = 1'b0;
    case (mode_r)
      MODE_THRESH: cmp = (sum_r >= thresh_r);
      MODE_ERODE:  cmp = (sum_r == KK);
      MODE_DILATE: cmp = (sum_r != '0);
      MODE_MAJ:    cmp = (sum_r > HALF);
      default:     cmp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sol_q   <= 1'b0;
      out_bit_q   <= 1'b0;
    end else begin
      out_valid_q <= valid_r;
      out_sol_q   <= valid_r & sol_r;
      out_bit_q   <= valid_r & (full_r ? cmp : EDGE_VAL);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sol   = out_sol_q;
  assign bus.out_bit   = out_bit_q;

endmodule

// File: tb/tb_bin_window_vote.sv
// Directed bench for bin_window_vote (K=5): expected bit streams are hand-derived.
module tb_bin_window_vote;

  localparam int K    = 5;
  localparam int SUMW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bin_window_vote_if #(.K(K), .SUMW(SUMW)) bus ();

  bin_window_vote #(.K(K), .SUMW(SUMW), .EDGE_VAL(1'b0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic b;
    logic s;
    int   c;
  } exp_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  string      scen    = "reset";
  exp_t       q[$];
  logic [4:0] cols [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      check({scen, ".sum_bound"}, int'(u_dut.sum <= 5'd25), 1);
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check({scen, ".spurious_out"}, 1, 0);
        end else begin
          e = q.pop_front();
          check({scen, ".out_bit"}, bus.out_bit, e.b);
          check({scen, ".out_sol"}, bus.out_sol, e.s);
          check({scen, ".latency"}, cyc, e.c);
        end
      end
    end
  end

  task automatic fill(input logic [4:0] v);
    for (int i = 0; i < 16; i++) cols[i] = v;
  endtask

  task automatic play(input int n, input logic [15:0] sols,
                      input logic [15:0] exp, input bit gaps);
    int waitc;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = 0;
        while (g < 3 && $urandom_range(1) == 1) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          bus.in_sol   = 1'($urandom_range(1));
          bus.in_col   = 5'($urandom);
          g++;
        end
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sol   = sols[i];
      bus.in_col   = cols[i];
      q.push_back('{b: exp[i], s: sols[i], c: cyc + 2});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sol   = 1'b0;
    waitc = 0;
    while (q.size() != 0 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check({scen, ".drain"}, q.size(), 0);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_sol     = 1'b0;
    bus.in_col     = '0;
    bus.cfg_mode   = 2'd0;
    bus.cfg_thresh = 5'd23;
    #1 rst_n = 1'b0;
    #1;
    check("reset.out_valid", bus.out_valid, 0);
    check("reset.out_sol",   bus.out_sol,   0);
    check("reset.out_bit",   bus.out_bit,   0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    scen = "s1_ones";
    fill(5'b11111);
    play(10, 16'h0001, 16'b0000001111110000, 1'b0);

    scen = "s2_sum23";
    fill(5'b11111); cols[6] = 5'b11100;
    play(14, 16'h0001, 16'b0011111111110000, 1'b0);

    scen = "s2_sum21";
    fill(5'b11111); cols[6] = 5'b10000;
    play(14, 16'h0001, 16'b0011100000110000, 1'b0);

    scen = "s3_dilate";
    bus.cfg_mode = 2'd2;
    fill(5'b00000); cols[5] = 5'b00100;
    play(14, 16'h0001, 16'b0000001111100000, 1'b0);

    scen = "s3_erode";
    bus.cfg_mode = 2'd1;
    play(14, 16'h0001, 16'b0000000000000000, 1'b0);

    scen = "sol_repeat";
    bus.cfg_mode = 2'd0;
    fill(5'b11111);
    play(8, 16'b0000000000000111, 16'b0000000011000000, 1'b0);

    scen = "s4_shadow";
    fill(5'b11111); cols[6] = 5'b11110;
    fork
      play(10, 16'h0001, 16'b0000001111110000, 1'b0);
      begin
        repeat (3) @(negedge clk);
        #1 bus.cfg_thresh = 5'd25;
      end
    join

    scen = "s4_thr25_ones";
    fill(5'b11111);
    play(10, 16'h0001, 16'b0000001111110000, 1'b0);

    scen = "s4_thr25_clear";
    cols[6] = 5'b11110;
    play(10, 16'h0001, 16'b0000000000110000, 1'b0);

    scen = "s5_gaps";
    bus.cfg_thresh = 5'd23;
    fill(5'b11111);
    play(10, 16'h0001, 16'b0000001111110000, 1'b1);
    scen = "s5_gaps2";
    cols[6] = 5'b10000;
    play(14, 16'h0001, 16'b0011100000110000, 1'b1);

    scen = "s6_reset";
    bus.cfg_thresh = 5'd25;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_sol = 1'b1; bus.in_col = 5'b11111;
    @(negedge clk);
    bus.in_sol = 1'b0;
    @(posedge clk);
    #2;
    check("s6.pre_rst_valid", bus.out_valid, 1);
    check("s6.pre_rst_sol",   bus.out_sol,   1);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("s6.rst_out_valid", bus.out_valid, 0);
    check("s6.rst_out_sol",   bus.out_sol,   0);
    check("s6.rst_out_bit",   bus.out_bit,   0);
    @(negedge clk);
    check("s6.rst_hold_valid", bus.out_valid, 0);
    #3 rst_n = 1'b1;

    scen = "s6_presol";
    bus.cfg_thresh = 5'd26;
    fill(5'b11111); cols[4] = 5'b11110;
    play(5, 16'h0000, 16'b0000000000010000, 1'b0);

    scen = "s6_rerun";
    bus.cfg_thresh = 5'd23;
    fill(5'b11111);
    play(10, 16'h0001, 16'b0000001111110000, 1'b0);

    check("final.queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
